// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared opcode/funct3 constants, LSU state type and helpers
//                for the byte-serial load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Index of the final byte of an access (access size minus one)
    function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational sign/zero extension of assembled load bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_word
);

    // Select extension rule from the access type
    always_comb begin
        o_word = i_bytes;
        case (i_funct3)
            F3_B:    o_word = {{24{i_bytes[7]}},  i_bytes[7:0]};
            F3_H:    o_word = {{16{i_bytes[15]}}, i_bytes[15:0]};
            F3_BU:   o_word = {24'd0, i_bytes[7:0]};
            F3_HU:   o_word = {16'd0, i_bytes[15:0]};
            default: o_word = i_bytes;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Sequences LOAD/STORE requests as 1/2/4 single-byte accesses
//                on a little-endian byte-wide memory port and returns the
//                extended load data or a store completion.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [6:0]        i_req_opcode,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    lsu_state_t        r_state, w_state_nxt;

    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [1:0]        r_last;
    logic              r_err;
    logic [31:0]       r_asm;
    logic              r_pend;
    logic [1:0]        r_pend_lane;
    logic [1:0]        r_out_lane;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_accept;
    logic              w_handshake;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_f3_ok;
    logic              w_misal;
    logic              w_req_err;
    logic [31:0]       w_asm;
    logic [31:0]       w_ext;
    logic              w_unused_addr;

    assign w_accept      = r_req_ready && i_req_valid;
    assign w_handshake   = r_resp_valid && i_resp_ready;
    assign w_unused_addr = ^i_req_addr[31:ADDR_W];

    // Request legality: opcode, funct3 for that opcode, optional alignment
    always_comb begin
        w_is_load  = (i_req_opcode == OPC_LOAD);
        w_is_store = (i_req_opcode == OPC_STORE);
        w_f3_ok    = 1'b0;
        if (w_is_load)
            w_f3_ok = (i_req_funct3 == F3_B)  || (i_req_funct3 == F3_H) ||
                      (i_req_funct3 == F3_W)  || (i_req_funct3 == F3_BU) ||
                      (i_req_funct3 == F3_HU);
        else if (w_is_store)
            w_f3_ok = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) ||
                      (i_req_funct3 == F3_W);
        w_misal = ALIGN_CHECK &&
                  (((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)));
        w_req_err = !w_f3_ok || w_misal;
    end

    // Load assembly including the byte arriving from memory this cycle, so
    // the final byte is usable on the same edge that raises the response
    always_comb begin
        w_asm = r_asm;
        if (r_pend)
            w_asm[{r_pend_lane, 3'b000} +: 8] = i_mem_rdata;
    end

    load_extend u_load_extend (
        .i_bytes  (w_asm),
        .i_funct3 (r_funct3),
        .o_word   (w_ext)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_req_err ? ST_RESP : ST_RUN;
            ST_RUN:   if (r_idx == r_last) w_state_nxt = r_is_store ? ST_RESP : ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_RESP;
            ST_RESP:  if (w_handshake) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs, driven from the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_idx        <= 2'd0;
            r_last       <= 2'd0;
            r_err        <= 1'b0;
            r_asm        <= 32'd0;
            r_pend       <= 1'b0;
            r_pend_lane  <= 2'd0;
            r_out_lane   <= 2'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'd0;
        end else begin
            r_req_ready <= (r_state == ST_IDLE) && !w_accept;
            r_mem_en    <= (r_state == ST_RUN);
            r_mem_we    <= (r_state == ST_RUN) && r_is_store;
            r_pend      <= r_mem_en && !r_mem_we;
            r_pend_lane <= r_out_lane;

            if (r_pend)
                r_asm[{r_pend_lane, 3'b000} +: 8] <= i_mem_rdata;

            if (w_accept) begin
                r_is_store <= w_is_store;
                r_funct3   <= i_req_funct3;
                r_addr     <= i_req_addr[ADDR_W-1:0];
                r_wdata    <= i_req_wdata;
                r_idx      <= 2'd0;
                r_last     <= last_byte_idx(i_req_funct3);
                r_err      <= w_req_err;
                r_asm      <= 32'd0;
            end

            if (r_state == ST_RUN) begin
                r_mem_addr  <= r_addr + ADDR_W'(r_idx);
                r_mem_wdata <= r_wdata[{r_idx, 3'b000} +: 8];
                r_out_lane  <= r_idx;
                r_idx       <= r_idx + 2'd1;
            end

            if ((r_state == ST_RESP) && !r_resp_valid) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= r_err;
                r_resp_rdata <= (r_err || r_is_store) ? 32'd0 : w_ext;
            end else if (w_handshake) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= 32'd0;
            end
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit. Instance 0 has no
//                alignment check, instance 1 has it; both see the same
//                request stream and each has its own byte memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [5:0] addr;
        logic       we;
        logic [7:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        mem_en     [2];
    logic        mem_we     [2];
    logic [5:0]  mem_addr   [2];
    logic [7:0]  mem_wdata  [2];
    logic [7:0]  mem_rdata  [2];

    logic [7:0]  tmem [2][64];
    logic [7:0]  mdl  [2][64];
    resp_t       rq   [2][$];
    acc_t        aq   [2][$];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          rr_mode = 0;
    bit          junk_en = 1'b0;
    bit          mem_load = 1'b1;

    logic        prev_valid [2];
    logic        prev_ready [2];
    logic [31:0] prev_rdata [2];
    logic        prev_err   [2];

    load_store_unit #(.ADDR_W(6), .ALIGN_CHECK(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
        .i_req_opcode(req_opcode), .i_req_funct3(req_funct3),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0]),
        .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0])
    );

    load_store_unit #(.ADDR_W(6), .ALIGN_CHECK(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
        .i_req_opcode(req_opcode), .i_req_funct3(req_funct3),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1]),
        .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 5) & 255);
    endfunction

    // Byte memories: registered read, write on enable
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_load) begin
                for (int a = 0; a < 64; a++) tmem[k][a] <= init_byte(a);
            end else if (mem_en[k]) begin
                if (mem_we[k]) tmem[k][mem_addr[k]] <= mem_wdata[k];
                else           mem_rdata[k] <= tmem[k][mem_addr[k]];
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: derive expected accesses and response from the rules
    function automatic void model(input int k, input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd, input int acc);
        bit legal, mis;
        int n, base;
        logic [31:0] v;
        resp_t r;
        if (opc == LD)      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else if (opc == ST) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else                legal = 1'b0;
        n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = int'(addr % 64);
        mis  = (k == 1) && (((n == 2) && (addr % 2 != 0)) || ((n == 4) && (addr % 4 != 0)));
        r.acc = acc;
        if (!legal || mis) begin
            r.rdata = 0; r.err = 1'b1; r.lat = 1;
        end else if (opc == ST) begin
            for (int i = 0; i < n; i++) begin
                int a;
                logic [7:0] b;
                a = (base + i) % 64;
                b = 8'((wd >> (8 * i)) & 255);
                aq[k].push_back('{6'(a), 1'b1, b});
                mdl[k][a] = b;
            end
            r.rdata = 0; r.err = 1'b0; r.lat = n + 1;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) begin
                int a;
                a = (base + i) % 64;
                aq[k].push_back('{6'(a), 1'b0, 8'h00});
                v = v + (32'(mdl[k][a]) << (8 * i));
            end
            if (f3 == 0 && v >= 128)   v = v | 32'hFFFF_FF00;
            if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
            r.rdata = v; r.err = 1'b0; r.lat = n + 2;
        end
        rq[k].push_back(r);
    endfunction

    // Monitor: access order, response latency/data, hold under backpressure
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                prev_valid[k] = 1'b0;
                prev_ready[k] = 1'b0;
            end else begin
                if (mem_en[k]) begin
                    if (aq[k].size() == 0) begin
                        chk($sformatf("unexpected_access%0d", k), 32'(mem_addr[k]), 32'hFFFF_FFFF);
                    end else begin
                        acc_t e;
                        e = aq[k].pop_front();
                        chk($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(e.addr));
                        chk($sformatf("mem_we%0d", k), 32'(mem_we[k]), 32'(e.we));
                        if (e.we) chk($sformatf("mem_wdata%0d", k), 32'(mem_wdata[k]), 32'(e.wdata));
                    end
                end
                if (prev_valid[k] && !prev_ready[k]) begin
                    chk($sformatf("hold_valid%0d", k), 32'(resp_valid[k]), 32'd1);
                    chk($sformatf("hold_rdata%0d", k), resp_rdata[k], prev_rdata[k]);
                    chk($sformatf("hold_err%0d", k), 32'(resp_err[k]), 32'(prev_err[k]));
                end
                if (resp_valid[k]) begin
                    chk($sformatf("req_ready_busy%0d", k), 32'(req_ready[k]), 32'd0);
                    if (!prev_valid[k]) begin
                        if (rq[k].size() == 0)
                            chk($sformatf("unexpected_resp%0d", k), 32'd1, 32'd0);
                        else
                            chk($sformatf("latency%0d", k), 32'(cyc - rq[k][0].acc), 32'(rq[k][0].lat));
                    end
                    if (resp_ready && rq[k].size() != 0) begin
                        resp_t r;
                        r = rq[k].pop_front();
                        chk($sformatf("resp_rdata%0d", k), resp_rdata[k], r.rdata);
                        chk($sformatf("resp_err%0d", k), 32'(resp_err[k]), 32'(r.err));
                    end
                end
                prev_valid[k] = resp_valid[k];
                prev_ready[k] = resp_ready;
                prev_rdata[k] = resp_rdata[k];
                prev_err[k]   = resp_err[k];
            end
        end
    end

    // Response-ready driver: 0 always ready, 1 random, 2 held low
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = 1'b1;
                2:       resp_ready = 1'b0;
                default: resp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int guard = 0;
        while (!(req_ready[0] && req_ready[1])) begin
            if (junk_en && !req_ready[0] && !req_ready[1] && ($urandom_range(0, 1) == 1)) begin
                req_valid  = 1'b1;
                req_opcode = ($urandom_range(0, 1) == 1) ? LD : ST;
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                req_valid = 1'b0;
                chk("issue_timeout", 32'd1, 32'd0);
                return;
            end
        end
        req_valid  = 1'b1;
        req_opcode = opc;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int k = 0; k < 2; k++) model(k, opc, f3, addr, wd, cyc + 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (rq[0].size() != 0 || rq[1].size() != 0 || aq[0].size() != 0 ||
               aq[1].size() != 0 || !req_ready[0] || !req_ready[1]) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 500) begin
                chk("drain_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 7'd0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 64; a++) mdl[k][a] = init_byte(a);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_req_ready%0d", k),  32'(req_ready[k]),  32'd1);
            chk($sformatf("rst_resp_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("rst_resp_err%0d", k),   32'(resp_err[k]),   32'd0);
            chk($sformatf("rst_resp_rdata%0d", k), resp_rdata[k],      32'd0);
            chk($sformatf("rst_mem_en%0d", k),     32'(mem_en[k]),     32'd0);
            chk($sformatf("rst_mem_we%0d", k),     32'(mem_we[k]),     32'd0);
            chk($sformatf("rst_mem_addr%0d", k),   32'(mem_addr[k]),   32'd0);
            chk($sformatf("rst_mem_wdata%0d", k),  32'(mem_wdata[k]),  32'd0);
        end
        mem_load = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases: store/extend, wrap, illegal encodings, alignment
        issue(ST, 3'b010, 32'h10, 32'hDEAD_BEEF);
        issue(LD, 3'b000, 32'h10, 32'h0);
        issue(LD, 3'b100, 32'h12, 32'h0);
        issue(LD, 3'b001, 32'h12, 32'h0);
        issue(ST, 3'b000, 32'h3F, 32'h11);
        issue(ST, 3'b010, 32'h00, 32'h0044_3322);
        issue(LD, 3'b010, 32'h3F, 32'h0);
        issue(ST, 3'b100, 32'h04, 32'h1234_5678);
        issue(LD, 3'b011, 32'h04, 32'h0);
        issue(7'h33, 3'b000, 32'h04, 32'h0);
        issue(LD, 3'b010, 32'h02, 32'h0);
        issue(LD, 3'b101, 32'hFFFF_FF3F, 32'h0);
        wait_idle();

        // Response held off for well over ten cycles
        rr_mode = 2;
        issue(LD, 3'b010, 32'h10, 32'h0);
        repeat (16) @(posedge clk);
        #1;
        rr_mode = 0;
        wait_idle();

        // Reset while a word store is mid-flight: only byte 0 lands
        req_opcode = ST;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'hA1B2_C3D4;
        req_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mdl[k][32] = 8'hD4;
            aq[k].push_back('{6'h20, 1'b1, 8'hD4});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_mem_en%0d", k),     32'(mem_en[k]),     32'd0);
            chk($sformatf("abort_req_ready%0d", k),  32'(req_ready[k]),  32'd1);
            chk($sformatf("abort_resp_valid%0d", k), 32'(resp_valid[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(LD, 3'b010, 32'h20, 32'h0);
        wait_idle();

        // Randomized traffic with random backpressure and ignored requests
        rr_mode = 1;
        junk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [6:0] opc;
            int sel;
            sel = $urandom_range(0, 9);
            opc = (sel < 5) ? LD : (sel < 9) ? ST : 7'($urandom);
            issue(opc, 3'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        junk_en = 1'b0;
        req_valid = 1'b0;
        rr_mode = 0;
        wait_idle();
        chk("resp_queue_empty", 32'(rq[0].size() + rq[1].size()), 32'd0);
        chk("access_queue_empty", 32'(aq[0].size() + aq[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
